maxpool2x2_sram: RTL
====================

Name: maxpool2x2_sram

Overview:
- 2x2 stride-2 max-pool stage inside the CNN accelerator `top`.
- Consumes the conv0 feature map already written to the two-port SRAM, 6 ch x 28x28 at words 0..4703.
- Writes pool1, 6 ch x 14x14, to words 4704..5879.
- Starts on a pulse from the top-level sequencer and reports completion with a level `done`, which the conv1 stage reads as its own start condition.

Parameters:
- DATA_W, 32: SRAM word width (INTERNAL_BITS); values are two's-complement signed.
- ADDR_W, 16: SRAM address width (SRAM_ADDR_BITS).
- CH, 6: number of channels.
- IN_DIM, 28: input feature-map side; must be even. OUT_DIM = IN_DIM/2.
- IN_BASE, 0: SRAM word address of channel 0, row 0, column 0 of the input.
- OUT_BASE, 4704: SRAM word address of the first pooled output.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-low reset (0 = reset).
- start, input, 1: one-cycle start pulse; ignored unless in IDLE or DONE.
- done, output, 1: high from completion until the next accepted start or reset.
- sram_aa, output, ADDR_W: port-A read address.
- sram_cena, output, 1: port-A enable, active-low.
- sram_qa, input, DATA_W: port-A read data; valid the cycle after `sram_cena`=0.
- sram_ab, output, ADDR_W: port-B write address.
- sram_cenb, output, 1: port-B enable, active-low.
- sram_wenb, output, 1: port-B write enable, active-low.
- sram_db, output, DATA_W: port-B write data.

Behaviour:
- Reset values: done=0, sram_cena=1, sram_cenb=1, sram_wenb=1, sram_aa=0, sram_ab=0, sram_db=0, all counters 0, state IDLE.
- Reset mid-operation aborts immediately. Any partially computed output is not written.
- FSM states: IDLE -> (start) RUN -> (last output written) DONE -> (start) RUN.
- A start while in RUN is ignored.
- Counters nest as ch (outer) / orow / ocol (inner), each wrapping 0..CH-1 / 0..OUT_DIM-1 / 0..OUT_DIM-1.
- Each output takes a 6-phase window, P0..P5:
  - P0..P3: sram_cena=0; sram_aa = IN_BASE + ch*IN_DIM^2 + (2*orow+dy)*IN_DIM + 2*ocol+dx, with (dy,dx) = (0,0),(0,1),(1,0),(1,1) in that order.
  - P1..P4: capture sram_qa. P1 loads the max register; P2..P4 replace it only if sram_qa > max (signed strict compare, so ties keep the earlier value).
  - P5: sram_cenb=0, sram_wenb=0, sram_ab = OUT_BASE + ch*OUT_DIM^2 + orow*OUT_DIM + ocol, sram_db = max. Counters then advance.
- Outside P0..P3, sram_cena=1. Outside P5, sram_cenb=1 and sram_wenb=1.
- Port A and port B never access the same address in the same cycle; input and output regions are disjoint by construction.
- Latency: the start pulse accepted in cycle T gives the first read in cycle T+1.
- The final write occurs in cycle T + 6*CH*OUT_DIM^2, which is 7056 cycles for the defaults.
- done rises one cycle after the final write.
- Address arithmetic uses ADDR_W-bit unsigned values with no overflow; the defaults reach at most 5879.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: in P5, a negative max (sign bit set) is written as 0. Fuses ReLU into the pool stage.
- Undefined: max is written unmodified.
- Timing is identical in both builds.

Decomposition:
- Shared package cnn_pool_pkg holds:
  - the DATA_W and ADDR_W defaults;
  - the state encoding {IDLE, RUN, DONE};
  - the phase encoding P0..P5;
  - region constants CONV0_BASE=0 and POOL1_BASE=4704.
- One sub-module, pool_addr_gen, holds the ch/orow/ocol counters plus the read and write address arithmetic. It has an advance strobe and a last flag.
- The top of this block keeps the FSM, phase counter, max register and SRAM strobes.

Test Plan:
- CH=1, IN_DIM=4, input words 0..15 = 1..16, start -> outputs 6, 8, 14, 16 written at OUT_BASE..OUT_BASE+3; done rises 25 cycles after start.
- Defaults, with SRAM words 0..4703 preloaded from conv0 golden, start -> words 4704..5879 match pool1 golden exactly; done rises at cycle T+7057.
- Window {0xFFFFFFF0, 0xFFFFFFFE, 0x80000000, 0xFFFFFFFF} -> writes 0xFFFFFFFF without POOL_RELU_EN, 0x00000000 with it.
- Window {5, 5, 3, 5} -> writes 5; check from the waveform that the max register loads in P1 and is not reloaded in P2 or P4.
- Second start pulse 100 cycles into RUN -> ignored: write count stays 1176 and completion cycle is unchanged.
- rst=0 for one cycle mid-RUN, then start -> strobes go inactive the cycle after reset; the rerun rewrites all outputs correctly and done is 0 until completion.

Source files
------------

// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the pool1 stage: default widths, SRAM region bases,
// FSM state and per-output phase encodings.
package cnn_pool_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned CONV0_BASE = 0;
  localparam int unsigned POOL1_BASE = 4704;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_P0,
    PH_P1,
    PH_P2,
    PH_P3,
    PH_P4,
    PH_P5
  } phase_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Channel/row/column walker for the 2x2 stride-2 pool; produces the window
// read address for tap i_tap and the pooled-output write address.
module pool_addr_gen
  import cnn_pool_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned CH       = 6,
  parameter int unsigned IN_DIM   = 28,
  parameter int unsigned IN_BASE  = CONV0_BASE,
  parameter int unsigned OUT_BASE = POOL1_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [1:0]        i_tap,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_last
);

  localparam int unsigned OUT_DIM = IN_DIM / 2;

  localparam logic [ADDR_W-1:0] C_IN_DIM   = ADDR_W'(IN_DIM);
  localparam logic [ADDR_W-1:0] C_IN_SQ    = ADDR_W'(IN_DIM * IN_DIM);
  localparam logic [ADDR_W-1:0] C_OUT_DIM  = ADDR_W'(OUT_DIM);
  localparam logic [ADDR_W-1:0] C_OUT_SQ   = ADDR_W'(OUT_DIM * OUT_DIM);
  localparam logic [ADDR_W-1:0] C_IN_BASE  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] C_OUT_BASE = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] C_CH_MAX   = ADDR_W'(CH - 1);
  localparam logic [ADDR_W-1:0] C_OD_MAX   = ADDR_W'(OUT_DIM - 1);

  logic [ADDR_W-1:0] r_ch;
  logic [ADDR_W-1:0] r_orow;
  logic [ADDR_W-1:0] r_ocol;
  logic              w_ch_last;
  logic              w_orow_last;
  logic              w_ocol_last;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_ch_last   = (r_ch == C_CH_MAX);
  assign w_orow_last = (r_orow == C_OD_MAX);
  assign w_ocol_last = (r_ocol == C_OD_MAX);
  assign o_last      = w_ch_last && w_orow_last && w_ocol_last;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_ch   <= '0;
      r_orow <= '0;
      r_ocol <= '0;
    end else if (i_adv) begin
      if (w_ocol_last) begin
        r_ocol <= '0;
        if (w_orow_last) begin
          r_orow <= '0;
          r_ch   <= w_ch_last ? '0 : r_ch + 1'b1;
        end else begin
          r_orow <= r_orow + 1'b1;
        end
      end else begin
        r_ocol <= r_ocol + 1'b1;
      end
    end
  end

  // i_tap[1] selects the lower input row, i_tap[0] the right-hand column
  assign w_row     = (r_orow << 1) + ADDR_W'(i_tap[1]);
  assign w_col     = (r_ocol << 1) + ADDR_W'(i_tap[0]);
  assign o_rd_addr = C_IN_BASE + r_ch * C_IN_SQ + w_row * C_IN_DIM + w_col;
  assign o_wr_addr = C_OUT_BASE + r_ch * C_OUT_SQ + r_orow * C_OUT_DIM + r_ocol;

endmodule

// File: rtl/maxpool2x2_sram.sv
// 2x2 stride-2 max-pool over conv0 in SRAM, writing pool1 back to SRAM.
// Define POOL_RELU_EN to clamp negative maxima to zero on write.
module maxpool2x2_sram
  import cnn_pool_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned CH       = 6,
  parameter int unsigned IN_DIM   = 28,
  parameter int unsigned IN_BASE  = CONV0_BASE,
  parameter int unsigned OUT_BASE = POOL1_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] sram_aa,
  output logic              sram_cena,
  input  logic [DATA_W-1:0] sram_qa,
  output logic [ADDR_W-1:0] sram_ab,
  output logic              sram_cenb,
  output logic              sram_wenb,
  output logic [DATA_W-1:0] sram_db
);

  state_t            r_state;
  state_t            w_state_nxt;
  phase_t            r_phase;
  phase_t            w_phase_nxt;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_wdata;
  logic              w_clr;
  logic              w_adv;
  logic              w_rd;
  logic              w_wr;
  logic              w_last;
  logic [1:0]        w_tap;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  pool_addr_gen #(
    .ADDR_W  (ADDR_W),
    .CH      (CH),
    .IN_DIM  (IN_DIM),
    .IN_BASE (IN_BASE),
    .OUT_BASE(OUT_BASE)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_adv    (w_adv),
    .i_tap    (w_tap),
    .o_rd_addr(w_rd_addr),
    .o_wr_addr(w_wr_addr),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_phase <= PH_P0;
      r_max   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      // read data lags the address by one cycle: taps land in P1..P4
      if (r_state == ST_RUN) begin
        if (r_phase == PH_P1) begin
          r_max <= sram_qa;
        end else if ((r_phase == PH_P2 || r_phase == PH_P3 || r_phase == PH_P4) &&
                     ($signed(sram_qa) > $signed(r_max))) begin
          r_max <= sram_qa;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_tap       = r_phase[1:0];
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = PH_P0;
          w_clr       = 1'b1;
        end
      end
      ST_RUN: begin
        w_rd = (r_phase <= PH_P3);
        w_wr = (r_phase == PH_P5);
        if (r_phase == PH_P5) begin
          w_phase_nxt = PH_P0;
          w_adv       = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_phase_nxt = phase_t'(r_phase + 3'd1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef POOL_RELU_EN
  assign w_wdata = r_max[DATA_W-1] ? '0 : r_max;
`else
  assign w_wdata = r_max;
`endif

  assign done      = (r_state == ST_DONE);
  assign sram_cena = ~w_rd;
  assign sram_aa   = w_rd ? w_rd_addr : '0;
  assign sram_cenb = ~w_wr;
  assign sram_wenb = ~w_wr;
  assign sram_ab   = w_wr ? w_wr_addr : '0;
  assign sram_db   = w_wr ? w_wdata : '0;

endmodule
